mult_sequencer: RTL and testbench

- Control stage directly upstream of the 3-bit Booth multiplier (`multiplicador`).
- Accepts operand pairs over a valid/ready handshake and registers them onto the multiplier's `Mcando`/`Mcador` inputs.
- Issues a one-cycle `start`, detects completion on `fin`, then captures `producto` and presents it over a valid/ready result handshake.
- Isolates the multiplier's bare start/fin protocol from the streaming datapath around it.

---
 rtl/mult_seq_pkg.sv | 25 ++
 rtl/mult_sequencer_fin_edge.sv | 33 +++
 rtl/mult_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mult_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_pkg
// Shared definitions for the multiplier sequencer slice.
//   state_e      : sequencer states IDLE / ISSUE / WAIT / HOLD
//   DEF_W        : default operand width, must match the Booth multiplier
//   DEF_TIMEOUT  : default WAIT-cycle limit before an abort
//                  (only used when MULT_SEQ_TIMEOUT_EN is defined)
//   DEF_CNT_W    : default width of the timeout counter
//   PW           : product width for the default operand width
// -----------------------------------------------------------------------------
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int DEF_W       = 3;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 5;
  localparam int PW          = 2 * DEF_W;

endpackage

// File: rtl/mult_sequencer_fin_edge.sv
// -----------------------------------------------------------------------------
// mult_fin_edge
// Registers the multiplier's fin level and flags its rising edge.
// The register comes out of reset at 1, so a fin level that is still high
// from an earlier operation (or held high through reset) is never seen as a
// new completion.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   fin_i  : multiplier fin level
//   rise_o : fin_i & ~fin_q, high in the cycle fin has just risen
// -----------------------------------------------------------------------------
module mult_fin_edge
  import mult_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic fin_i,
  output logic rise_o
);

  logic fin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_q <= 1'b1;
    end else begin
      fin_q <= fin_i;
    end
  end

  assign rise_o = fin_i & ~fin_q;

endmodule

// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
// Control stage in front of the 3-bit Booth multiplier. Takes operand pairs
// on a valid/ready handshake, holds them on the multiplier inputs, pulses
// start for one cycle, waits for a fresh rising edge of fin, captures the
// product and offers it on a valid/ready result handshake. One operation is
// in flight at a time.
//
// Ports:
//   clk, rst_n                  : clock (rising edge), async active-low reset
//   in_valid / in_ready         : operand handshake
//   in_mcando, in_mcador [W]    : two's complement multiplicand / multiplier
//   out_valid / out_ready       : result handshake
//   out_producto [2W]           : product, copied bit-for-bit from multiplier
//   out_err                     : result was aborted by timeout
//   busy                        : sequencer is not IDLE
//   mult_mcando, mult_mcador [W]: registered operands to the multiplier
//   mult_start                  : one-cycle start pulse to the multiplier
//   mult_producto [2W], mult_fin: multiplier product and completion level
//
// Optional feature, macro MULT_SEQ_TIMEOUT_EN:
//   defined   - WAIT aborts after TIMEOUT cycles without completion, giving a
//               HOLD result with out_err=1 and out_producto=0.
//   undefined - no counter is built, WAIT waits forever, out_err stays 0.
// -----------------------------------------------------------------------------
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_mcando,
  input  logic [W-1:0]   in_mcador,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_producto,
  output logic           out_err,
  output logic           busy,
  output logic [W-1:0]   mult_mcando,
  output logic [W-1:0]   mult_mcador,
  output logic           mult_start,
  input  logic [2*W-1:0] mult_producto,
  input  logic           mult_fin
);

  if ((1 << CNT_W) <= TIMEOUT) begin : g_bad_cnt_w
    $error("mult_sequencer: CNT_W too narrow for TIMEOUT");
  end

  state_e         state_q, state_d;
  logic [W-1:0]   mcando_q, mcando_d;
  logic [W-1:0]   mcador_q, mcador_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic           err_q, err_d;
  logic           finRise;
  logic           timeoutHit;

  mult_fin_edge u_fin_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .fin_i  (mult_fin),
    .rise_o (finRise)
  );

`ifdef MULT_SEQ_TIMEOUT_EN
  // cnt_q counts completed WAIT cycles; the abort fires at the end of the
  // TIMEOUT-th WAIT cycle, i.e. while cnt_q still reads TIMEOUT-1.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeoutHit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // Next-state logic. Completion is only acted on in WAIT, which drops both
  // edges seen during ISSUE and late edges of an aborted operation.
  always_comb begin
    state_d  = state_q;
    mcando_d = mcando_q;
    mcador_d = mcador_q;
    prod_d   = prod_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcando_d = in_mcando;
          mcador_d = in_mcador;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (finRise) begin
          prod_d  = mult_producto;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (timeoutHit) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcando_q <= '0;
      mcador_q <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcando_q <= mcando_d;
      mcador_q <= mcador_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
    end
  end

  // in_ready is gated by rst_n so it reads 0 while reset is held, even
  // though the state register already sits in IDLE.
  assign in_ready     = (state_q == IDLE) & rst_n;
  assign out_valid    = (state_q == HOLD);
  assign mult_start   = (state_q == ISSUE);
  assign busy         = (state_q != IDLE);
  assign out_producto = prod_q;
  // err_q can only be set by the timeout path, so it is constant 0 when the
  // timeout feature is not built.
  assign out_err      = err_q;
  assign mult_mcando  = mcando_q;
  assign mult_mcador  = mcador_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
// Self-checking bench for mult_sequencer. A behavioural multiplier stub sits
// on the mult_* side; a scoreboard predicts every result from the accepted
// operands and is compared against the DUT on every falling edge. Directed
// tests pin the scoreboard with hand-computed products.
// Build with MULT_SEQ_TIMEOUT_EN defined to also exercise the timeout.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;
  import mult_seq_pkg::*;

  localparam int W = DEF_W;

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic          mult_start, mult_fin;
  logic [W-1:0]  in_mcando, in_mcador, mult_mcando, mult_mcador;
  logic [PW-1:0] out_producto, mult_producto;

  int testCount = 0;
  int failCount = 0;

  mult_sequencer #(.W(W), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mcando     (in_mcando),
    .in_mcador     (in_mcador),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_producto  (out_producto),
    .out_err       (out_err),
    .busy          (busy),
    .mult_mcando   (mult_mcando),
    .mult_mcador   (mult_mcador),
    .mult_start    (mult_start),
    .mult_producto (mult_producto),
    .mult_fin      (mult_fin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference signed product of two W-bit two's complement operands.
  function automatic logic [PW-1:0] mulRef(input logic [W-1:0] a, input logic [W-1:0] b);
    int pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    return PW'(pa * pb);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Multiplier stub: start drops fin and loads a latency counter; fin rises
  // with the product when it expires. fin either stays high until the next
  // start (stale mode) or drops after one cycle (pulse mode). While fin is
  // low the product bus carries noise so capture timing is exercised.
  int            stubLat = 2;
  bit            stubPulse = 1'b0;
  bit            stubHang = 1'b0;
  bit            lateFin = 1'b0;
  logic          stubFin;
  int            stubCnt;
  logic [W-1:0]  stubA, stubB;
  logic [PW-1:0] stubProd, stubNoise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stubFin  <= 1'b1;
      stubCnt  <= 0;
      stubProd <= '0;
      stubA    <= '0;
      stubB    <= '0;
    end else if (mult_start) begin
      stubFin <= 1'b0;
      stubCnt <= stubLat;
      stubA   <= mult_mcando;
      stubB   <= mult_mcador;
    end else if (stubCnt == 1) begin
      if (!stubHang) begin
        stubFin  <= 1'b1;
        stubCnt  <= 0;
        stubProd <= mulRef(stubA, stubB);
      end
    end else if (stubCnt > 1) begin
      stubCnt <= stubCnt - 1;
    end else if (stubFin && stubPulse) begin
      stubFin <= 1'b0;
    end
  end

  always @(posedge clk) stubNoise <= PW'($urandom);

  assign mult_fin      = stubFin | lateFin;
  assign mult_producto = stubFin ? stubProd : stubNoise;

  // Scoreboard: one entry {err, product} per accepted operand pair. Checked
  // on every falling edge, when all DUT outputs are settled.
  logic [PW:0]  expQ[$];
  logic [W-1:0] opA = '0, opB = '0;
  bit           expectStart = 1'b0;
  int           outCount = 0;
  int           startPulses = 0;
  logic [PW-1:0] lastOut = '0;
  logic         lastErr = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      expectStart = 1'b0;
      opA = '0;
      opB = '0;
    end else begin
      checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() == 0));
      checkOutput("busy", 32'(busy), 32'(expQ.size() != 0));
      checkOutput("mult_start", 32'(mult_start), 32'(expectStart));
      checkOutput("mult_mcando", 32'(mult_mcando), 32'(opA));
      checkOutput("mult_mcador", 32'(mult_mcador), 32'(opB));
      if (mult_start) startPulses++;
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious out_valid", 32'(out_valid), 32'(0));
        end else begin
          checkOutput("out_producto", 32'(out_producto), 32'(expQ[0][PW-1:0]));
          checkOutput("out_err", 32'(out_err), 32'(expQ[0][PW]));
        end
        if (out_ready) begin
          lastOut = out_producto;
          lastErr = out_err;
          outCount++;
          if (expQ.size() != 0) void'(expQ.pop_front());
        end
      end
      expectStart = in_valid && in_ready;
      if (in_valid && in_ready) begin
        opA = in_mcando;
        opB = in_mcador;
        if (stubHang) expQ.push_back({1'b1, {PW{1'b0}}});
        else          expQ.push_back({1'b0, mulRef(in_mcando, in_mcador)});
      end
    end
  end

  // Random result backpressure, active only while randReady is set.
  bit randReady = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one operand pair and wait for it to be accepted. Returns one
  // time unit after the accepting edge; hold keeps in_valid asserted.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    bit took;
    took = 1'b0;
    in_valid  = 1'b1;
    in_mcando = a;
    in_mcador = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        took = 1'b1;
        break;
      end
    end
    if (!took) checkOutput("accept timeout", 32'(took), 32'(1));
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitOutputs(input int target);
    for (int i = 0; i < 300; i++) begin
      if (outCount >= target) break;
      @(posedge clk);
      #1;
    end
    if (outCount < target) checkOutput("result timeout", 32'(outCount), 32'(target));
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    checkOutput("return to idle", 32'(busy), 32'(0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ctrl"}, 32'({in_ready, out_valid, out_err, busy, mult_start}), 32'(0));
    checkOutput({tag, " out_producto"}, 32'(out_producto), 32'(0));
    checkOutput({tag, " operands"}, 32'({mult_mcando, mult_mcador}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n0, s0, cyc;
    bit sawValid;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_mcando = '0;
    in_mcador = '0;
    out_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 3 x 2
    n0 = outCount;
    s0 = startPulses;
    applyStimulus(3'd3, 3'd2, 1'b0);
    waitOutputs(n0 + 1);
    checkOutput("basic product", 32'(lastOut), 32'(6'b000110));
    checkOutput("basic err", 32'(lastErr), 32'(0));
    checkOutput("basic start pulses", 32'(startPulses - s0), 32'(1));

    // Signed -3 x 3
    n0 = outCount;
    applyStimulus(3'b101, 3'b011, 1'b0);
    waitOutputs(n0 + 1);
    checkOutput("signed product", 32'(lastOut), 32'(6'b110111));

    // Backpressure: hold out_ready low for 5 cycles of out_valid
    out_ready = 1'b0;
    applyStimulus(3'd3, 3'd2, 1'b0);
    sawValid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        sawValid = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("bp out_valid seen", 32'(sawValid), 32'(1));
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp out_producto", 32'(out_producto), 32'(6'b000110));
      checkOutput("bp flags", 32'({out_valid, in_ready, busy}), 32'(3'b101));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp release", 32'({out_valid, in_ready, busy}), 32'(3'b010));

    // Back-to-back with a stale fin
    stubPulse = 1'b0;
    n0 = outCount;
    applyStimulus(3'd2, 3'd2, 1'b1);
    applyStimulus(3'd1, 3'd3, 1'b0);
    waitOutputs(n0 + 2);
    checkOutput("stale second product", 32'(lastOut), 32'(6'b000011));

    // Reset three cycles into WAIT
    stubLat = 6;
    applyStimulus(3'd2, 3'd3, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("mid-wait reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    stubLat = 2;
    n0 = outCount;
    applyStimulus(3'b111, 3'b111, 1'b0);
    waitOutputs(n0 + 1);
    checkOutput("after reset product", 32'(lastOut), 32'(6'b000001));

`ifdef MULT_SEQ_TIMEOUT_EN
    // Timeout: fin never rises; HOLD after 16 WAIT cycles, late fin ignored
    stubHang  = 1'b1;
    out_ready = 1'b0;
    applyStimulus(3'd1, 3'd1, 1'b0);
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
    checkOutput("timeout cycles", 32'(cyc), 32'(17));
    checkOutput("timeout err", 32'(out_err), 32'(1));
    checkOutput("timeout product", 32'(out_producto), 32'(0));
    lateFin = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1 lateFin = 1'b0;
    stubHang = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("late fin ignored", 32'({out_valid, busy}), 32'(0));
`else
    cyc = 0;
    checkOutput("err tied low", 32'(out_err), 32'(cyc));
`endif

    // Randomised operations with random latency, fin style and backpressure
    randReady = 1'b1;
    for (int k = 0; k < 40; k++) begin
      stubLat   = $urandom_range(1, 5);
      stubPulse = $urandom_range(0, 1) == 1;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      applyStimulus(W'($urandom), W'($urandom), $urandom_range(0, 3) == 0);
    end
    in_valid  = 1'b0;
    randReady = 1'b0;
    out_ready = 1'b1;
    waitIdle();
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
